// File: rtl/multi_cycle_executor.sv
// multi_cycle_executor
//   Multi-cycle integer executor for OP-IMM (0010011) and OP (0110011)
//   instructions. It owns its own register file. Each accepted instruction
//   walks IDLE -> READ -> EXEC -> WB -> IDLE, so it takes four cycles.
//   Retire and illegal pulses are registered on the edge that leaves WB.
//   The register write happens on that same edge.
//
// Parameters
//   XLEN          datapath width (32 or 64)
//   REG_ADDR_W    register index width (5 -> 32 regs, 4 -> 16 regs)
//   RETIRE_CNT_W  width of the retired-instruction counter
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   instr_valid     instruction offered
//   instr_ready     executor can accept (IDLE and not in reset)
//   instruction     32-bit instruction word, captured on accept
//   retire_valid    one-cycle pulse: legal instruction completed
//   retire_rd       rd field of the completing instruction
//   retire_data     result of the completing instruction (0 when rd==0)
//   illegal         one-cycle pulse: accepted instruction was rejected
//   retire_count    legal retirements, wraps
//   dbg_addr/data   combinational register-file read port (x0 reads 0)

module multi_cycle_executor #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [31:0]             instruction,
  output logic                    retire_valid,
  output logic [4:0]              retire_rd,
  output logic [XLEN-1:0]         retire_data,
  output logic                    illegal,
  output logic [RETIRE_CNT_W-1:0] retire_count,
  input  logic [REG_ADDR_W-1:0]   dbg_addr,
  output logic [XLEN-1:0]         dbg_data
);

  localparam int SW    = $clog2(XLEN);
  localparam int NREGS = 1 << REG_ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Position of instr[30] inside instr[31:20+SW]. It is the only upper
  // bit that a shift-immediate may set, and only for SRAI.
  localparam logic [11-SW:0] SRA_BIT = {1'b0, 1'b1, {(10-SW){1'b0}}};

  logic [1:0]      state;
  logic [31:0]     ir;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            bad;
  logic [XLEN-1:0] regs [NREGS];

  // Instruction fields of the latched word.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;

  assign opcode = ir[6:0];
  assign rd_f   = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1_f  = ir[19:15];
  assign rs2_f  = ir[24:20];
  assign funct7 = ir[31:25];

  logic is_op;
  logic is_op_imm;
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);

  logic [REG_ADDR_W-1:0] rs1_idx;
  logic [REG_ADDR_W-1:0] rs2_idx;
  logic [REG_ADDR_W-1:0] rd_idx;
  assign rs1_idx = rs1_f[REG_ADDR_W-1:0];
  assign rs2_idx = rs2_f[REG_ADDR_W-1:0];
  assign rd_idx  = rd_f[REG_ADDR_W-1:0];

  logic [XLEN-1:0] imm;
  assign imm = {{(XLEN-12){ir[31]}}, ir[31:20]};

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  assign rs1_val = regs[rs1_idx];
  assign rs2_val = regs[rs2_idx];

  assign instr_ready = (state == S_IDLE) & ~rst;
  assign dbg_data    = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // Illegal-instruction decode, evaluated while in READ.
  logic [11-SW:0] shift_hi;
  logic [11-SW:0] shift_hi_ok;
  logic           dec_illegal;

  assign shift_hi    = ir[31:20+SW];
  assign shift_hi_ok = (funct3 == 3'b101) ? SRA_BIT : '0;

  // NOTE: every variable assigned in always_comb gets a default first.
  // Otherwise a path that leaves it unassigned infers a latch.
  always_comb begin
    dec_illegal = 1'b0;
    if (!is_op && !is_op_imm) dec_illegal = 1'b1;
    if (is_op) begin
      if (funct7 == 7'b0100000) begin
        if (funct3 != 3'b000 && funct3 != 3'b101) dec_illegal = 1'b1;
      end else if (funct7 != 7'b0000000) begin
        dec_illegal = 1'b1;
      end
    end
    if (is_op_imm && (funct3 == 3'b001 || funct3 == 3'b101)) begin
      if ((shift_hi & ~shift_hi_ok) != '0) dec_illegal = 1'b1;
    end
    // The 16-register variant cannot address x16..x31.
    if (REG_ADDR_W < 5) begin
      if (rd_f[4] || rs1_f[4] || (is_op && rs2_f[4])) dec_illegal = 1'b1;
    end
  end

  // ALU. It works on the operands latched in READ. For OP-IMM the low SW
  // bits of the immediate are instr[20+SW-1:20], so op_b supplies the
  // shift amount for both formats.
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_out;
  assign shamt = op_b[SW-1:0];

  always_comb begin
    alu_out = '0;
    case (funct3)
      3'b000: begin
        if (is_op && ir[30]) alu_out = op_a - op_b;
        else                 alu_out = op_a + op_b;
      end
      3'b001: alu_out = op_a << shamt;
      3'b010: alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100: alu_out = op_a ^ op_b;
      3'b101: begin
        // NOTE: the arithmetic shift stays in its own statement. In a
        // ternary with an unsigned branch, $signed(op_a) is treated as
        // unsigned and >>> degrades to a logical shift.
        if (ir[30]) alu_out = $signed(op_a) >>> shamt;
        else        alu_out = op_a >> shamt;
      end
      3'b110: alu_out = op_a | op_b;
      default: alu_out = op_a & op_b;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ir           <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      bad          <= 1'b0;
      retire_valid <= 1'b0;
      illegal      <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      retire_count <= '0;
    end else begin
      retire_valid <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instruction;
            state <= S_READ;
          end
        end
        S_READ: begin
          op_a  <= rs1_val;
          op_b  <= is_op ? rs2_val : imm;
          bad   <= dec_illegal;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_out;
          state  <= S_WB;
        end
        default: begin
          state <= S_IDLE;
          if (bad) begin
            illegal <= 1'b1;
          end else begin
            retire_valid <= 1'b1;
            retire_rd    <= rd_f;
            retire_data  <= (rd_f == 5'd0) ? '0 : result;
            retire_count <= retire_count + RETIRE_CNT_W'(1);
          end
        end
      endcase
    end
  end

  // NOTE: the register file is built from flops, not a RAM macro. It must
  // read as zero after reset, so every entry is cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == S_WB && !bad && rd_idx != '0) begin
      regs[rd_idx] <= result;
    end
  end

endmodule

// File: tb/tb_multi_cycle_executor.sv
// Testbench for multi_cycle_executor.
//   dut_a: default parameters (XLEN=32, 32 registers, 32-bit counter).
//   dut_b: XLEN=64, 16 registers, 4-bit counter.
// Expected values below are hand-computed from the instruction encodings.

module tb_multi_cycle_executor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // dut_a signals
  logic        valid_a;
  logic        ready_a;
  logic [31:0] instr_a;
  logic        rv_a;
  logic [4:0]  rrd_a;
  logic [31:0] rdata_a;
  logic        ill_a;
  logic [31:0] cnt_a;
  logic [4:0]  dbg_addr_a;
  logic [31:0] dbg_data_a;

  // dut_b signals
  logic        valid_b;
  logic        ready_b;
  logic [31:0] instr_b;
  logic        rv_b;
  logic [4:0]  rrd_b;
  logic [63:0] rdata_b;
  logic        ill_b;
  logic [3:0]  cnt_b;
  logic [3:0]  dbg_addr_b;
  logic [63:0] dbg_data_b;

  multi_cycle_executor dut_a (
    .clk(clk), .rst(rst),
    .instr_valid(valid_a), .instr_ready(ready_a), .instruction(instr_a),
    .retire_valid(rv_a), .retire_rd(rrd_a), .retire_data(rdata_a),
    .illegal(ill_a), .retire_count(cnt_a),
    .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
  );

  multi_cycle_executor #(.XLEN(64), .REG_ADDR_W(4), .RETIRE_CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .instr_valid(valid_b), .instr_ready(ready_b), .instruction(instr_b),
    .retire_valid(rv_b), .retire_rd(rrd_b), .retire_data(rdata_b),
    .illegal(ill_b), .retire_count(cnt_b),
    .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic rd_dbg(input bit sel, input logic [4:0] a, output logic [63:0] d);
    if (sel) dbg_addr_b = a[3:0];
    else     dbg_addr_a = a;
    #1;
    d = sel ? dbg_data_b : {32'h0, dbg_data_a};
  endtask

  // Offers one instruction and waits (bounded) for acceptance. It then
  // measures the number of edges from accept to the retire/illegal pulse
  // and checks that the pulse lasts exactly one cycle.
  task automatic issue(input bit sel, input logic [31:0] ins,
                       output logic got_rv, output logic got_ill,
                       output logic [4:0] got_rd, output logic [63:0] got_data,
                       output int lat);
    int  waited;
    bit  seen;
    got_rv = 1'b0; got_ill = 1'b0; got_rd = '0; got_data = '0; lat = -1;
    seen = 1'b0;
    @(negedge clk);
    if (sel) begin valid_b = 1'b1; instr_b = ins; end
    else     begin valid_a = 1'b1; instr_a = ins; end
    waited = 0;
    while (!(sel ? ready_b : ready_a) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!(sel ? ready_b : ready_a)) begin
      check("accept_timeout", 64'd0, 64'd1);
      valid_a = 1'b0; valid_b = 1'b0;
    end else begin
      @(negedge clk);  // the accepting edge (E0) lies just behind us
      valid_a = 1'b0; valid_b = 1'b0;
      for (int k = 1; k <= 8 && !seen; k++) begin
        @(negedge clk);
        if (sel ? (rv_b | ill_b) : (rv_a | ill_a)) begin
          seen     = 1'b1;
          lat      = k;
          got_rv   = sel ? rv_b : rv_a;
          got_ill  = sel ? ill_b : ill_a;
          got_rd   = sel ? rrd_b : rrd_a;
          got_data = sel ? rdata_b : {32'h0, rdata_a};
        end
      end
      if (seen) begin
        @(negedge clk);
        check("pulse_one_cycle", 64'(sel ? (rv_b | ill_b) : (rv_a | ill_a)), 64'd0);
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        exp_ill;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [4:0]  dbg_reg;
    logic [31:0] exp_dbg;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [31:0] ins,
                              input logic ill, input logic [4:0] rd,
                              input logic [31:0] data, input logic [4:0] dreg,
                              input logic [31:0] dval);
    vec_t v;
    v.name = n; v.ins = ins; v.exp_ill = ill; v.exp_rd = rd;
    v.exp_data = data; v.dbg_reg = dreg; v.exp_dbg = dval;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic        g_rv;
    logic        g_ill;
    logic [4:0]  g_rd;
    logic [63:0] g_data;
    logic [63:0] d;
    int          lat;
    int          exp_cnt_a;
    int          exp_cnt_b;
    int          accepts;
    int          retires;
    int          pulses;
    int          nonzero;

    vecs.push_back(mk("addi_neg",   32'hFFB00093, 0, 5'd1,  32'hFFFFFFFB, 5'd1,  32'hFFFFFFFB));
    vecs.push_back(mk("addi_7",     32'h00700113, 0, 5'd2,  32'h00000007, 5'd2,  32'h00000007));
    vecs.push_back(mk("sub",        32'h401101B3, 0, 5'd3,  32'h0000000C, 5'd3,  32'h0000000C));
    vecs.push_back(mk("slt",        32'h0020A233, 0, 5'd4,  32'h00000001, 5'd4,  32'h00000001));
    vecs.push_back(mk("sltu",       32'h0020B2B3, 0, 5'd5,  32'h00000000, 5'd5,  32'h00000000));
    vecs.push_back(mk("srai",       32'h4010D313, 0, 5'd6,  32'hFFFFFFFD, 5'd6,  32'hFFFFFFFD));
    vecs.push_back(mk("srli",       32'h0010D313, 0, 5'd6,  32'h7FFFFFFD, 5'd6,  32'h7FFFFFFD));
    vecs.push_back(mk("slli_b25",   32'h02109313, 1, 5'd0,  32'h0,        5'd6,  32'h7FFFFFFD));
    vecs.push_back(mk("srli_b31",   32'h8010D313, 1, 5'd0,  32'h0,        5'd6,  32'h7FFFFFFD));
    vecs.push_back(mk("addi_x0",    32'h00500013, 0, 5'd0,  32'h00000000, 5'd0,  32'h00000000));
    vecs.push_back(mk("load",       32'h00002083, 1, 5'd0,  32'h0,        5'd1,  32'hFFFFFFFB));
    vecs.push_back(mk("xori",       32'h0F00C393, 0, 5'd7,  32'hFFFFFF0B, 5'd7,  32'hFFFFFF0B));
    vecs.push_back(mk("ori_neg",    32'hFF016413, 0, 5'd8,  32'hFFFFFFF7, 5'd8,  32'hFFFFFFF7));
    vecs.push_back(mk("andi",       32'h7FF0F493, 0, 5'd9,  32'h000007FB, 5'd9,  32'h000007FB));
    vecs.push_back(mk("sll",        32'h00211533, 0, 5'd10, 32'h00000380, 5'd10, 32'h00000380));
    vecs.push_back(mk("sra",        32'h4020D5B3, 0, 5'd11, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFF));
    vecs.push_back(mk("sltiu_m1",   32'hFFF13613, 0, 5'd12, 32'h00000001, 5'd12, 32'h00000001));
    vecs.push_back(mk("slti_m4",    32'hFFC0A693, 0, 5'd13, 32'h00000001, 5'd13, 32'h00000001));
    vecs.push_back(mk("op_f7_sll",  32'h40211533, 1, 5'd0,  32'h0,        5'd10, 32'h00000380));
    vecs.push_back(mk("op_mul",     32'h02208733, 1, 5'd0,  32'h0,        5'd14, 32'h00000000));
    vecs.push_back(mk("or",         32'h0020E7B3, 0, 5'd15, 32'hFFFFFFFF, 5'd15, 32'hFFFFFFFF));
    vecs.push_back(mk("and",        32'h0020F833, 0, 5'd16, 32'h00000003, 5'd16, 32'h00000003));
    vecs.push_back(mk("add",        32'h002088B3, 0, 5'd17, 32'h00000002, 5'd17, 32'h00000002));
    vecs.push_back(mk("xor",        32'h0020C933, 0, 5'd18, 32'hFFFFFFFC, 5'd18, 32'hFFFFFFFC));
    vecs.push_back(mk("srl",        32'h0020D9B3, 0, 5'd19, 32'h01FFFFFF, 5'd19, 32'h01FFFFFF));

    valid_a = 1'b0; instr_a = '0; dbg_addr_a = '0;
    valid_b = 1'b0; instr_b = '0; dbg_addr_b = '0;
    exp_cnt_a = 0; exp_cnt_b = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.ready_low", 64'(ready_a), 64'd0);
    rst = 1'b0;
    #1;
    check("rst.ready_high", 64'(ready_a), 64'd1);
    check("rst.retire_valid", 64'(rv_a), 64'd0);
    check("rst.illegal", 64'(ill_a), 64'd0);
    check("rst.retire_rd", 64'(rrd_a), 64'd0);
    check("rst.retire_data", 64'(rdata_a), 64'd0);
    check("rst.retire_count", 64'(cnt_a), 64'd0);
    rd_dbg(0, 5'd1, d);
    check("rst.dbg_x1", d, 64'd0);

    // Table-driven vectors on dut_a
    foreach (vecs[i]) begin
      issue(0, vecs[i].ins, g_rv, g_ill, g_rd, g_data, lat);
      check({vecs[i].name, ".latency"}, 64'(lat), 64'd3);
      check({vecs[i].name, ".illegal"}, 64'(g_ill), 64'(vecs[i].exp_ill));
      check({vecs[i].name, ".retire_valid"}, 64'(g_rv), 64'(!vecs[i].exp_ill));
      if (!vecs[i].exp_ill) begin
        exp_cnt_a++;
        check({vecs[i].name, ".retire_rd"}, 64'(g_rd), 64'(vecs[i].exp_rd));
        check({vecs[i].name, ".retire_data"}, g_data, 64'(vecs[i].exp_data));
      end
      check({vecs[i].name, ".retire_count"}, 64'(cnt_a), 64'(exp_cnt_a));
      rd_dbg(0, vecs[i].dbg_reg, d);
      check({vecs[i].name, ".dbg"}, d, 64'(vecs[i].exp_dbg));
    end

    // instr_valid held high for 16 cycles: exactly 4 accepts and 4 retires.
    // ADDI x20,x20,1 starting from x20=0.
    @(negedge clk);
    valid_a = 1'b1; instr_a = 32'h001A0A13;
    accepts = 0; retires = 0;
    for (int n = 0; n < 16; n++) begin
      if (ready_a) accepts++;
      @(negedge clk);
      if (rv_a) retires++;
    end
    valid_a = 1'b0;
    exp_cnt_a += 4;
    check("hold.accepts", 64'(accepts), 64'd4);
    check("hold.retires", 64'(retires), 64'd4);
    check("hold.retire_count", 64'(cnt_a), 64'(exp_cnt_a));
    rd_dbg(0, 5'd20, d);
    check("hold.dbg_x20", d, 64'd4);

    // Reset asserted during EXEC of ADDI x7,x0,9
    @(negedge clk);
    valid_a = 1'b1; instr_a = 32'h00900393;
    check("mid.ready_before", 64'(ready_a), 64'd1);
    @(negedge clk);  // accepted; now READ
    valid_a = 1'b0;
    @(negedge clk);  // now EXEC
    rst = 1'b1;
    #1;
    check("mid.ready_in_rst", 64'(ready_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid.ready_after_rst", 64'(ready_a), 64'd1);
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rv_a | ill_a) pulses++;
    end
    check("mid.no_pulse", 64'(pulses), 64'd0);
    check("mid.ready_idle", 64'(ready_a), 64'd1);
    check("mid.retire_count", 64'(cnt_a), 64'd0);
    check("mid.retire_rd", 64'(rrd_a), 64'd0);
    check("mid.retire_data", 64'(rdata_a), 64'd0);
    rd_dbg(0, 5'd7, d);
    check("mid.dbg_x7", d, 64'd0);
    nonzero = 0;
    for (int r = 0; r < 32; r++) begin
      rd_dbg(0, 5'(r), d);
      if (d != 64'd0) nonzero++;
    end
    check("mid.all_regs_zero", 64'(nonzero), 64'd0);

    // dut_b: XLEN=64, 16 registers, 4-bit retire counter
    issue(1, 32'hFFF00093, g_rv, g_ill, g_rd, g_data, lat);  // ADDI x1,x0,-1
    exp_cnt_b++;
    check("b.addi_m1.rv", 64'(g_rv), 64'd1);
    check("b.addi_m1.data", g_data, 64'hFFFFFFFF_FFFFFFFF);
    issue(1, 32'h4280D113, g_rv, g_ill, g_rd, g_data, lat);  // SRAI x2,x1,40
    exp_cnt_b++;
    check("b.srai40.latency", 64'(lat), 64'd3);
    check("b.srai40.data", g_data, 64'hFFFFFFFF_FFFFFFFF);
    issue(1, 32'h0280D193, g_rv, g_ill, g_rd, g_data, lat);  // SRLI x3,x1,40
    exp_cnt_b++;
    check("b.srli40.data", g_data, 64'h00000000_00FFFFFF);
    issue(1, 32'h00100813, g_rv, g_ill, g_rd, g_data, lat);  // ADDI x16,x0,1
    check("b.rd16.illegal", 64'(g_ill), 64'd1);
    check("b.rd16.rv", 64'(g_rv), 64'd0);
    issue(1, 32'h00180193, g_rv, g_ill, g_rd, g_data, lat);  // ADDI x3,x16,1
    check("b.rs1_16.illegal", 64'(g_ill), 64'd1);
    rd_dbg(1, 5'd3, d);
    check("b.dbg_x3", d, 64'h00000000_00FFFFFF);
    for (int n = 0; n < 14; n++) begin
      issue(1, 32'h00120213, g_rv, g_ill, g_rd, g_data, lat);  // ADDI x4,x4,1
      exp_cnt_b++;
    end
    check("b.count_wrap_17", 64'(cnt_b), 64'(exp_cnt_b % 16));
    check("b.count_is_1", 64'(cnt_b), 64'd1);
    rd_dbg(1, 5'd4, d);
    check("b.dbg_x4", d, 64'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_executor.md
Name: multi_cycle_executor

Overview:
- Parametrised successor to the single-instruction ALU datapath.
- Owns an internal integer register file and executes RV32I/RV64I-style OP-IMM (0010011) and OP (0110011) instructions.
- Runs a 4-state multi-cycle FSM with a valid/ready instruction handshake, a retire interface, an illegal-instruction flag, a retire counter and a debug read port.
- Sits between the future fetch unit and the register file/ALU, and replaces the single-instruction path.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; shamt width SW = log2(XLEN).
- REG_ADDR_W, 5, register index width; 5 gives 32 registers, 4 gives 16 registers (E-variant).
- RETIRE_CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  executor can accept; = (state==IDLE) & ~rst.
- instruction  input  32  instruction word; sampled when instr_valid & instr_ready.
- retire_valid  output  1  one-cycle pulse: instruction completed.
- retire_rd  output  5  rd field of the completing instruction.
- retire_data  output  XLEN  result of the completing instruction; 0 when rd==0.
- illegal  output  1  one-cycle pulse: the accepted instruction was rejected.
- retire_count  output  RETIRE_CNT_W  count of legal retired instructions; wraps.
- dbg_addr  input  REG_ADDR_W  debug register index.
- dbg_data  output  XLEN  combinational register file read; x0 reads 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all registers = 0.
  - retire_valid, illegal, retire_rd, retire_data, retire_count = 0.
  - Any in-flight instruction is abandoned: no write, no pulse, no count.
- FSM:
  - IDLE -> READ on accept. Instruction is latched.
  - READ: decode, operands read. rs1 is always read; for OP, rs2 is also read. Imm = sign-extend instr[31:20] to XLEN (not zero-extended). -> EXEC.
  - EXEC: ALU result latched. -> WB.
  - WB: retire_valid=1 (legal) or illegal=1 (illegal). Register write takes effect at the edge leaving WB. -> IDLE.
- Latency and throughput:
  - Accept at edge E0; retire pulse is visible during the cycle after edge E0+3.
  - Throughput is 1 instruction per 4 cycles.
  - instr_ready=0 in READ/EXEC/WB.
  - instr_valid while not ready is ignored; no buffering.
- ALU by funct3:
  - 000: ADD; SUB only for OP with funct7=0100000.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL; SRA when instr[30]=1.
  - 110: OR.
  - 111: AND.
  - SLTI/SLTIU compare against the sign-extended immediate.
- Shifts:
  - OP uses rs2[SW-1:0] as the shift amount; OP-IMM uses instr[20+SW-1:20].
  - OP-IMM shifts: instr[31:20+SW] must be all zero, except bit 30, which may be 1 only for funct3=101.
- Illegal (decided in READ, pulsed in WB with the same latency; no write; counter unchanged):
  - opcode not 0010011/0110011;
  - OP funct7 not 0000000, or 0100000 with funct3 not in {000,101};
  - OP-IMM shift encoding violation;
  - with REG_ADDR_W=4, bit 4 of rd/rs1/rs2 set (rs2 is checked for OP only).
- x0:
  - Writes with rd=0 are discarded.
  - retire_valid still pulses and retire_count increments.
  - retire_data = 0.
- retire_rd/retire_data:
  - Hold their last value outside WB; 0 after reset.
- retire_count:
  - Increments on each retire_valid; wraps from all-ones to 0.
- dbg_data:
  - Reflects a write from the edge that ends WB onward.
- Reset asserted in any state: takes effect immediately. On deassertion the FSM is in IDLE and instr_ready rises.

Test Plan:
- After reset, ADDI x1,x0,-5 (0xFFB00093) -> retire 3 cycles after accept; retire_rd=1; retire_data=0xFFFFFFFB; dbg x1=0xFFFFFFFB; retire_count=1.
- ADDI x2,x0,7; SUB x3,x2,x1 (0x401101B3); SLT x4,x1,x2; SLTU x5,x1,x2 -> x3=12, x4=1, x5=0. Check instr_valid is held high across non-ready cycles and only 4 instructions are accepted.
- SRAI x6,x1,1 (0x4010D313) -> 0xFFFFFFFD. SRLI same source -> 0x7FFFFFFD. SLLI with instr[25]=1 (XLEN=32) -> illegal pulse; x6 unchanged; count unchanged.
- ADDI x0,x0,5 -> retire_valid=1, retire_data=0, dbg x0=0. Opcode 0000011 (load) -> illegal=1, retire_valid=0.
- Assert rst during EXEC of ADDI x7,x0,9 -> no retire; x7=0; all registers 0; instr_ready=1 the cycle after rst falls.
- RETIRE_CNT_W=4: 17 legal instructions -> retire_count=1. XLEN=64: SRAI by 40 on -1 -> all-ones; REG_ADDR_W=4: rd=x16 -> illegal.
